// File: rtl/pc_gen.sv
// Program-counter generator for the instruction-fetch stage.
// Drives pc/ce toward imem with a ce/ack handshake. Redirects that arrive
// while a fetch is outstanding are buffered until that fetch is acked.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall[STALL_W]     pipeline stall vector, bit 0 holds the PC
//   flush, flush_pc    exception/eret redirect
//   branch_flag/target taken branch from decode
//   ack                imem accepted the fetch at pc this cycle
//   pc, ce             fetch address and fetch request valid
//   kill               acked fetch is wrong-path (combinational)
//   align_err          misaligned target loaded (PC_ALIGN_CHECK_EN only)
// Optional feature macro: PC_ALIGN_CHECK_EN. When it is undefined,
// loaded targets have their low bits forced to zero instead.
module pc_gen #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int          INST_BYTES = 4,
    parameter int          STALL_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              ack,
`ifdef PC_ALIGN_CHECK_EN
    output logic              align_err,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              kill
);

    typedef enum logic {S_RST, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LOW_BITS = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic              ce_q, ce_n;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_n;
    logic              pend_valid_q, pend_valid_n;
    logic              pend_flush_q, pend_flush_n;
    logic              ld;
    logic [ADDR_W-1:0] ld_addr;
    logic              outstanding, accept;
    logic              unused_stall;

`ifdef PC_ALIGN_CHECK_EN
    logic aerr_q, aerr_n;
    assign align_err = aerr_q;
`else
    logic aerr_q;
    assign aerr_q = 1'b0;
`endif

    function automatic logic [ADDR_W-1:0] tgt(input logic [ADDR_W-1:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return a;
`else
        return a & ~LOW_BITS;
`endif
    endfunction

    // Only stall[0] matters to the PC; the rest belongs to later stages.
    assign unused_stall = ^stall;

    assign pc          = pc_q;
    assign ce          = ce_q & ~aerr_q;
    assign outstanding = ce & ~ack;
    assign accept      = ce & ack;
    // Branches never kill: the in-flight fetch is the delay slot.
    assign kill = accept & (flush | (pend_valid_q & pend_flush_q));

    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        ce_n         = ce_q;
        pend_pc_n    = pend_pc_q;
        pend_valid_n = pend_valid_q;
        pend_flush_n = pend_flush_q;
        ld           = 1'b0;
        ld_addr      = pc_q;
`ifdef PC_ALIGN_CHECK_EN
        aerr_n       = aerr_q;
`endif
        unique case (state_q)
            S_RST: begin
                state_n = S_RUN;
                ce_n    = 1'b1;
            end
            S_RUN: begin
                if (aerr_q) begin
                    // Fetch halted; only a flush restarts it.
                    if (flush) begin
                        ld           = 1'b1;
                        ld_addr      = flush_pc;
                        pend_valid_n = 1'b0;
                        pend_flush_n = 1'b0;
                    end
                end else if (outstanding) begin
                    if (flush) begin
                        pend_pc_n    = flush_pc;
                        pend_valid_n = 1'b1;
                        pend_flush_n = 1'b1;
                    end else if (branch_flag && !stall[0] &&
                                 !(pend_valid_q && pend_flush_q)) begin
                        pend_pc_n    = branch_target;
                        pend_valid_n = 1'b1;
                    end
                end else if (accept) begin
                    if (flush) begin
                        ld           = 1'b1;
                        ld_addr      = flush_pc;
                        pend_valid_n = 1'b0;
                        pend_flush_n = 1'b0;
                    end else if (pend_valid_q) begin
                        ld           = 1'b1;
                        ld_addr      = pend_pc_q;
                        pend_valid_n = 1'b0;
                        pend_flush_n = 1'b0;
                    end else if (stall[0]) begin
                        pc_n = pc_q;
                    end else if (branch_flag) begin
                        ld      = 1'b1;
                        ld_addr = branch_target;
                    end else begin
                        pc_n = pc_q + STEP;
                    end
                end
            end
            default: state_n = S_RST;
        endcase
        if (ld) begin
            pc_n = tgt(ld_addr);
`ifdef PC_ALIGN_CHECK_EN
            aerr_n = |(ld_addr & LOW_BITS);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RST;
            pc_q         <= RST_PC;
            ce_q         <= 1'b0;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_flush_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            aerr_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            ce_q         <= ce_n;
            pend_pc_q    <= pend_pc_n;
            pend_valid_q <= pend_valid_n;
            pend_flush_q <= pend_flush_n;
`ifdef PC_ALIGN_CHECK_EN
            aerr_q       <= aerr_n;
`endif
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, backpressure, pending redirects,
// flush priority, stall, wrap and target alignment handling.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        ack;
    logic [31:0] pc;
    logic        ce;
    logic        kill;
`ifdef PC_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .flush_pc(flush_pc),
        .branch_flag(branch_flag),
        .branch_target(branch_target),
        .ack(ack),
`ifdef PC_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .pc(pc),
        .ce(ce),
        .kill(kill)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0;
        branch_flag = 1'b0; branch_target = '0; ack = 1'b1;

        // reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ce", {31'b0, ce}, 32'h0);
            chk("rst_pc", pc, 32'h0);
        end
        rst = 1'b0;
        step();
        chk("rel_ce", {31'b0, ce}, 32'h1);
        chk("rel_pc", pc, 32'h0);
        step(); chk("seq4", pc, 32'h4);
        step(); chk("seq8", pc, 32'h8);
        step(); chk("seqC", pc, 32'hC);
        step(); chk("seq10", pc, 32'h10);

        // backpressure
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_kill", {31'b0, kill}, 32'h0);
            step();
            chk("bp_pc", pc, 32'h10);
            chk("bp_ce", {31'b0, ce}, 32'h1);
        end
        ack = 1'b1;
        #1 chk("bp_ack_kill", {31'b0, kill}, 32'h0);
        step(); chk("bp_next", pc, 32'h14);
        step(); step(); step();
        chk("at20", pc, 32'h20);

        // branch buffered during an outstanding fetch
        ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h100;
        step(); chk("pend_hold1", pc, 32'h20);
        branch_flag = 1'b0;
        step(); chk("pend_hold2", pc, 32'h20);
        ack = 1'b1;
        #1 chk("pend_kill", {31'b0, kill}, 32'h0);
        step(); chk("pend_pc", pc, 32'h100);

        // flush beats branch and stall
        flush = 1'b1; flush_pc = 32'h180;
        branch_flag = 1'b1; branch_target = 32'h200; stall = 6'h1;
        #1 chk("fl_kill", {31'b0, kill}, 32'h1);
        step(); chk("fl_pc", pc, 32'h180);
        flush = 1'b0; branch_flag = 1'b0; stall = '0;
        step(); chk("fl_drop", pc, 32'h184);

        // buffered flush is not overwritten by a later branch
        ack = 1'b0; flush = 1'b1; flush_pc = 32'h300;
        step();
        flush = 1'b0; branch_flag = 1'b1; branch_target = 32'h400;
        step(); chk("pf_hold", pc, 32'h184);
        branch_flag = 1'b0; ack = 1'b1;
        #1 chk("pf_kill", {31'b0, kill}, 32'h1);
        step(); chk("pf_pc", pc, 32'h300);

        // branch ignored under stall, taken once released
        stall = 6'h1; branch_flag = 1'b1; branch_target = 32'h400;
        step(); chk("bs_hold", pc, 32'h300);
        stall = '0;
        #1 chk("br_kill", {31'b0, kill}, 32'h0);
        step(); chk("br_pc", pc, 32'h400);
        branch_flag = 1'b0;

`ifndef PC_ALIGN_CHECK_EN
        // misaligned target has its low bits cleared
        flush = 1'b1; flush_pc = 32'h502;
        step(); chk("mask_pc", pc, 32'h500);
        flush = 1'b0;
`endif

        // stall at top of address space, then wrap
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        step(); chk("top_pc", pc, 32'hFFFF_FFFC);
        flush = 1'b0; stall = 6'h1;
        step(); chk("st1", pc, 32'hFFFF_FFFC);
        step(); chk("st2", pc, 32'hFFFF_FFFC);
        stall = '0;
        step(); chk("wrap", pc, 32'h0);

        // reset while waiting discards the pending branch
        ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h700;
        step();
        branch_flag = 1'b0; rst = 1'b1;
        step();
        chk("mr_pc", pc, 32'h0);
        chk("mr_ce", {31'b0, ce}, 32'h0);
        rst = 1'b0;
        step(); chk("mr_ce1", {31'b0, ce}, 32'h1);
        ack = 1'b1;
        step(); chk("mr_seq", pc, 32'h4);

`ifdef PC_ALIGN_CHECK_EN
        flush = 1'b1; flush_pc = 32'h102;
        step();
        flush = 1'b0;
        chk("ae_set", {31'b0, align_err}, 32'h1);
        chk("ae_ce", {31'b0, ce}, 32'h0);
        chk("ae_pc", pc, 32'h102);
        branch_flag = 1'b1; branch_target = 32'h800;
        step(); chk("ae_hold", pc, 32'h102);
        branch_flag = 1'b0;
        flush = 1'b1; flush_pc = 32'h200;
        step();
        flush = 1'b0;
        chk("ae_clr", {31'b0, align_err}, 32'h0);
        chk("ae_ce1", {31'b0, ce}, 32'h1);
        chk("ae_pc2", pc, 32'h200);
        step(); chk("ae_seq", pc, 32'h204);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
